// File: rtl/pd_pkg.sv
// Shared types and constants for the power-detect RAM readout slice.
package pd_pkg;

  localparam int ANW_DEF  = 2;
  localparam int SANW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } pd_state_e;

  // RAM address width: {sf, ant}
  function automatic int addr_w(input int sanw, input int anw);
    return sanw + anw;
  endfunction

  // Address of the final entry of a frame: {sf_num-1, ant_num-1}
  function automatic int last_addr(input int sf_num, input int ant_num, input int anw);
    return ((sf_num - 1) << anw) | (ant_num - 1);
  endfunction

endpackage

// File: rtl/pd_rd_ctrl_if.sv
// RAM read port plus valid/ready entry stream between the readout
// scheduler (master) and the RAM / downstream consumer (slave).
interface pd_rd_ctrl_if
  import pd_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = addr_w(SANW_DEF, ANW_DEF)
);

  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic [AW-1:0] o_addr;
  logic          o_last;

  modport master (
    output ram_rd_en, ram_rd_addr, o_valid, o_data, o_addr, o_last,
    input  ram_rd_data, o_ready
  );

  modport slave (
    input  ram_rd_en, ram_rd_addr, o_valid, o_data, o_addr, o_last,
    output ram_rd_data, o_ready
  );

endinterface

// File: rtl/pd_skid_fifo.sv
// Small synchronous FIFO holding RAM read returns until the consumer takes
// them. The caller reserves a slot before each read, so it never overflows.
module pd_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;

  // Storage write
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= (wp == PMAX) ? '0 : wp + 1'b1;
      if (pop)  rp <= (rp == PMAX) ? '0 : rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign dout = mem[rp];

endmodule

// File: rtl/pd_rd_ctrl.sv
// Power-detect RAM readout scheduler: detects a completed frame-end capture,
// reads every {sf,ant} entry in order under a credit limit, streams the
// entries out and raises per-antenna threshold alarms once per frame.
module pd_rd_ctrl
  import pd_pkg::*;
#(
  parameter int ANT_NUM     = 4,
  parameter int ANW         = ANW_DEF,
  parameter int SANW        = SANW_DEF,
  parameter int SF_ADDR_NUM = 20,
  parameter int DW          = 32,
  parameter int RD_LAT      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        get_end_wr,
  input  logic [addr_w(SANW,ANW)-1:0] get_end_addr,
  input  logic                        cfg_en,
  input  logic [DW-1:0]               cfg_thr,
  pd_rd_ctrl_if.master                bus,
  output logic [ANT_NUM-1:0]          alarm,
  output logic                        busy,
  output logic                        overrun
);

  localparam int            AW    = addr_w(SANW, ANW);
  localparam int            DEPTH = RD_LAT + 2;
  localparam int            CW    = $clog2(DEPTH + 1);
  localparam int            FW    = DW + AW + 1;
  localparam logic [AW-1:0] LAST  = AW'(last_addr(SF_ADDR_NUM, ANT_NUM, ANW));

  pd_state_e          state;
  logic               wr_d, last_seen, cap_done;
  logic [DW-1:0]      thr;
  logic [ANT_NUM-1:0] acc;
  logic [AW-1:0]      nxt_addr;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic [CW-1:0]      in_flight;
  logic [RD_LAT-1:0]  vld_pipe;
  logic [AW-1:0]      addr_pipe [RD_LAT];
  logic               push, pop, valid, start, can_issue, issue;
  logic [AW-1:0]      issue_addr, push_addr;
  logic [CW:0]        occupied;
  logic [CW-1:0]      fifo_cnt;
  logic [FW-1:0]      fifo_din, fifo_dout;

  // Next address in {sf,ant} order; ant wraps at ANT_NUM, never reaching 2**ANW
  function automatic logic [AW-1:0] adv(input logic [AW-1:0] a);
    logic [SANW-1:0] s;
    logic [ANW-1:0]  t;
    s = a[AW-1:ANW];
    t = a[ANW-1:0];
    if (t == ANW'(ANT_NUM - 1)) begin
      s = s + 1'b1;
      t = '0;
    end else begin
      t = t + 1'b1;
    end
    return {s, t};
  endfunction

  assign cap_done = wr_d & ~get_end_wr & last_seen;

  // Capture-complete detection: last address written, then write enable falls
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_d      <= 1'b0;
      last_seen <= 1'b0;
    end else begin
      wr_d <= get_end_wr;
      if (cap_done)
        last_seen <= 1'b0;
      else if (get_end_wr && get_end_addr == LAST)
        last_seen <= 1'b1;
    end
  end

  // Read credit: a slot is reserved from issue until the entry leaves the
  // FIFO; a same-cycle pop frees a slot so steady state sustains 1/clock.
  always_comb begin
    pop        = valid & bus.o_ready;
    occupied   = {1'b0, in_flight} + {1'b0, fifo_cnt} - {{CW{1'b0}}, pop};
    can_issue  = occupied < (CW+1)'(DEPTH);
    start      = (state == IDLE) && cap_done && cfg_en;
    issue      = start || ((state == READ) && can_issue);
    issue_addr = start ? '0 : nxt_addr;
  end

  // Readout FSM with registered read strobe, alarm and overrun outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      nxt_addr <= '0;
      thr      <= '0;
      acc      <= '0;
      alarm    <= '0;
      overrun  <= 1'b0;
    end else begin
      rd_en   <= issue;
      overrun <= cap_done && (state != IDLE);
      if (issue) begin
        rd_addr  <= issue_addr;
        nxt_addr <= adv(issue_addr);
      end
      if (push) begin
        for (int unsigned a = 0; a < ANT_NUM; a++)
          if (push_addr[ANW-1:0] == ANW'(a) && bus.ram_rd_data > thr)
            acc[a] <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state <= (issue_addr == LAST) ? DRAIN : READ;
            thr   <= cfg_thr;
            acc   <= '0;
          end
        end
        READ: begin
          if (can_issue && nxt_addr == LAST) state <= DRAIN;
        end
        DRAIN: begin
          if (in_flight == '0 && fifo_cnt == '0) state <= DONE;
        end
        DONE: begin
          alarm <= acc;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In-flight accounting and read-latency alignment of valid/address
  always_ff @(posedge clk) begin
    if (reset) begin
      in_flight <= '0;
      vld_pipe  <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) addr_pipe[i] <= '0;
    end else begin
      case ({issue, push})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: ;
      endcase
      vld_pipe[0]  <= rd_en;
      addr_pipe[0] <= rd_addr;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  assign push      = vld_pipe[RD_LAT-1];
  assign push_addr = addr_pipe[RD_LAT-1];
  assign fifo_din  = {push_addr == LAST, push_addr, bus.ram_rd_data};

  pd_skid_fifo #(
    .DEPTH (DEPTH),
    .W     (FW),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_cnt)
  );

  assign valid           = (fifo_cnt != '0);
  assign bus.o_valid     = valid;
  assign bus.o_data      = valid ? fifo_dout[DW-1:0]  : '0;
  assign bus.o_addr      = valid ? fifo_dout[DW +: AW] : '0;
  assign bus.o_last      = valid & fifo_dout[FW-1];
  assign bus.ram_rd_en   = rd_en;
  assign bus.ram_rd_addr = rd_addr;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_pd_rd_ctrl.sv
// Scoreboard bench for pd_rd_ctrl with a 2-cycle RAM model.
module tb_pd_rd_ctrl;

  localparam int DW = 32;
  localparam int AW = 7;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          get_end_wr = 1'b0;
  logic [AW-1:0] get_end_addr = '0;
  logic          cfg_en = 1'b1;
  logic [DW-1:0] cfg_thr = '0;
  logic [3:0]    alarm;
  logic          busy;
  logic          overrun;

  pd_rd_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  pd_rd_ctrl #(
    .ANT_NUM     (4),
    .ANW         (2),
    .SANW        (5),
    .SF_ADDR_NUM (20),
    .DW          (DW),
    .RD_LAT      (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .get_end_wr   (get_end_wr),
    .get_end_addr (get_end_addr),
    .cfg_en       (cfg_en),
    .cfg_thr      (cfg_thr),
    .bus          (bus),
    .alarm        (alarm),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ready_mode = 0;
  int issued, accepted, max_out, ovr_cnt, last_cnt, first_en_cyc, first_vld_cyc;
  ent_t sb[$];
  logic [DW-1:0] ram [128];
  logic [DW-1:0] d1, d2;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // RAM model: data appears two clocks after the read strobe
  always @(posedge clk) begin
    d1 <= ram[bus.ram_rd_addr];
    d2 <= d1;
  end
  assign bus.ram_rd_data = d2;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Monitor: drives o_ready, checks accepted entries against the scoreboard
  initial begin : mon
    logic          stalled;
    logic [DW-1:0] st_data;
    logic [AW-1:0] st_addr;
    stalled = 1'b0;
    st_data = '0;
    st_addr = '0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       bus.o_ready = 1'b1;
        1:       bus.o_ready = 1'($urandom_range(0, 1));
        default: bus.o_ready = 1'b0;
      endcase
      if (reset) begin
        stalled = 1'b0;
        continue;
      end
      if (overrun) ovr_cnt++;
      if (bus.ram_rd_en) begin
        issued++;
        if (first_en_cyc < 0) first_en_cyc = cyc;
      end
      if (bus.o_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (stalled) begin
        chk("stall_valid", longint'(bus.o_valid), 1);
        chk("stall_data", longint'(bus.o_data), longint'(st_data));
        chk("stall_addr", longint'(bus.o_addr), longint'(st_addr));
      end
      if (bus.o_valid && bus.o_ready) begin
        accepted++;
        if (bus.o_last) last_cnt++;
        chk("sb_nonempty", longint'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          ent_t e;
          e = sb.pop_front();
          chk("o_addr", longint'(bus.o_addr), longint'(e.addr));
          chk("o_data", longint'(bus.o_data), longint'(e.data));
          chk("o_last", longint'(bus.o_last), longint'(e.last));
        end
      end
      stalled = bus.o_valid && !bus.o_ready;
      st_data = bus.o_data;
      st_addr = bus.o_addr;
    end
  end

  task automatic set_ram_addr();
    for (int i = 0; i < 128; i++) ram[i] = DW'(i);
  endtask

  task automatic set_ram_const(input logic [DW-1:0] v);
    for (int i = 0; i < 128; i++) ram[i] = v;
  endtask

  task automatic clear_stats();
    issued = 0; accepted = 0; max_out = 0; ovr_cnt = 0; last_cnt = 0;
    first_en_cyc = -1; first_vld_cyc = -1;
  endtask

  task automatic push_frame();
    for (int sf = 0; sf < 20; sf++)
      for (int a = 0; a < 4; a++) begin
        ent_t e;
        e.addr = AW'(sf * 4 + a);
        e.data = ram[e.addr];
        e.last = (sf == 19) && (a == 3);
        sb.push_back(e);
      end
  endtask

  function automatic logic [3:0] model_alarm(input logic [DW-1:0] thr);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 80; i++)
      if (ram[i] > thr) m[i % 4] = 1'b1;
    return m;
  endfunction

  task automatic capture(input int n_sf, input bit expect_read, output int cap_cyc);
    for (int sf = 0; sf < n_sf; sf++)
      for (int a = 0; a < 4; a++) begin
        @(negedge clk);
        get_end_wr   = 1'b1;
        get_end_addr = AW'(sf * 4 + a);
      end
    @(negedge clk);
    get_end_wr   = 1'b0;
    get_end_addr = '0;
    cap_cyc      = cyc;
    if (expect_read) push_frame();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_in_time"}, longint'(n < 3000), 1);
  endtask

  initial begin : main
    int cc;
    int n;
    logic [3:0] exp_al;
    clear_stats();
    set_ram_addr();
    repeat (3) @(negedge clk);
    chk("rst_rd_en",   longint'(bus.ram_rd_en), 0);
    chk("rst_o_valid", longint'(bus.o_valid), 0);
    chk("rst_busy",    longint'(busy), 0);
    chk("rst_alarm",   longint'(alarm), 0);
    chk("rst_overrun", longint'(overrun), 0);
    reset = 1'b0;
    @(negedge clk);

    // Full sweep, o_ready held high: latency, order, throughput, alarm
    cfg_thr = 32'd77; ready_mode = 0; clear_stats();
    capture(20, 1'b1, cc);
    @(negedge clk);
    chk("A_busy_up", longint'(busy), 1);
    wait_idle("A");
    chk("A_first_en_lat",  longint'(first_en_cyc - cc), 1);
    chk("A_first_vld_lat", longint'(first_vld_cyc - first_en_cyc), 3);
    chk("A_issued",   issued, 80);
    chk("A_accepted", accepted, 80);
    chk("A_last_cnt", last_cnt, 1);
    chk("A_max_outstanding", max_out, 4);
    exp_al = model_alarm(32'd77);
    chk("A_alarm", longint'(alarm), longint'(exp_al));
    chk("A_busy_idle", longint'(busy), 0);

    // Random backpressure
    cfg_thr = '1; ready_mode = 1; clear_stats();
    capture(20, 1'b1, cc);
    wait_idle("B");
    chk("B_accepted", accepted, 80);
    chk("B_outstanding_le4", longint'(max_out <= 4), 1);
    chk("B_alarm", longint'(alarm), 0);

    // Alarm on a single entry one above threshold, then cleared next frame
    set_ram_const(32'd100); ram[7*4+2] = 32'd101;
    cfg_thr = 32'd100; ready_mode = 0; clear_stats();
    capture(20, 1'b1, cc);
    wait_idle("C");
    chk("C_alarm", longint'(alarm), 4'b0100);
    set_ram_const(32'd100); clear_stats();
    capture(20, 1'b1, cc);
    wait_idle("D");
    chk("D_alarm", longint'(alarm), 4'b0000);

    // Overrun: second capture completes while the first is stalled
    set_ram_addr(); cfg_thr = '0; ready_mode = 2; clear_stats();
    capture(20, 1'b1, cc);
    repeat (10) @(negedge clk);
    chk("E_credit_stall", issued, 4);
    capture(20, 1'b0, cc);
    repeat (3) @(negedge clk);
    chk("E_overrun_pulses", ovr_cnt, 1);
    chk("E_busy_held", longint'(busy), 1);
    ready_mode = 0;
    wait_idle("E");
    repeat (20) @(negedge clk);
    chk("E_issued",   issued, 80);
    chk("E_accepted", accepted, 80);
    chk("E_busy_end", longint'(busy), 0);
    chk("E_overrun_total", ovr_cnt, 1);
    exp_al = model_alarm('0);
    chk("E_alarm", longint'(alarm), longint'(exp_al));

    // Partial window and disabled capture are ignored
    clear_stats();
    capture(11, 1'b0, cc);
    repeat (10) @(negedge clk);
    chk("F_partial_busy",   longint'(busy), 0);
    chk("F_partial_issued", issued, 0);
    cfg_en = 1'b0; clear_stats();
    capture(20, 1'b0, cc);
    repeat (10) @(negedge clk);
    chk("F_dis_busy",    longint'(busy), 0);
    chk("F_dis_issued",  issued, 0);
    chk("F_dis_overrun", ovr_cnt, 0);
    cfg_en = 1'b1;

    // Reset mid-readout, then a clean frame
    cfg_thr = 32'd77; ready_mode = 0; clear_stats();
    capture(20, 1'b1, cc);
    n = 0;
    while (accepted < 30 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("G_reach30", longint'(accepted >= 30), 1);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("G_rst_rd_en",   longint'(bus.ram_rd_en), 0);
    chk("G_rst_o_valid", longint'(bus.o_valid), 0);
    chk("G_rst_o_data",  longint'(bus.o_data), 0);
    chk("G_rst_o_addr",  longint'(bus.o_addr), 0);
    chk("G_rst_o_last",  longint'(bus.o_last), 0);
    chk("G_rst_alarm",   longint'(alarm), 0);
    chk("G_rst_busy",    longint'(busy), 0);
    chk("G_rst_overrun", longint'(overrun), 0);
    sb.delete();
    clear_stats();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_stats();
    capture(20, 1'b1, cc);
    wait_idle("H");
    chk("H_issued",   issued, 80);
    chk("H_accepted", accepted, 80);
    chk("H_last_cnt", last_cnt, 1);
    exp_al = model_alarm(32'd77);
    chk("H_alarm", longint'(alarm), longint'(exp_al));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
